serial_adder_accum: RTL and testbench

Bit-serial adder that consumes two parallel operands and produces their sum one bit per clock. It uses the team's half-adder logic internally, with two half adders forming a full adder and a registered carry. It sits directly downstream of the combinational half-adder stage and extends it to multi-bit operands with a start/done handshake. Area stays small, which suits a Tiny Tapeout tile.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/full_add_cell.sv | 39 +++
 rtl/serial_adder_accum.sv | 142 ++++++++++++++
 tb/tb_serial_adder_accum.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// The optional signed overflow flag is selected in the top module by SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter only has to reach WIDTH-1; keep at least one bit for WIDTH=2.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_add_cell.sv
// One-bit full adder assembled from two half adders and a carry-merge OR.
// Purely combinational; sits in the serial adder's per-bit datapath.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;
endmodule

module full_add_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    logic w_p;
    logic w_g;
    logic w_pc;

    half_adder u_ha_ab (
        .i_a     (i_a),
        .i_b     (i_b),
        .o_sum   (w_p),
        .o_carry (w_g)
    );

    half_adder u_ha_pc (
        .i_a     (w_p),
        .i_b     (i_cin),
        .o_sum   (o_sum),
        .o_carry (w_pc)
    );

    assign o_cout = w_g | w_pc;
endmodule

// File: rtl/serial_adder_accum.sv
// Bit-serial adder: captures two operands on start, emits the sum after WIDTH RUN cycles with a one-cycle done pulse.
// Signed overflow output is only built when SERIAL_ADDER_OVF_EN is defined; otherwise ovf is tied low.
module serial_adder_accum
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovf
);
    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_busy;
    logic             w_done;
    logic             w_load;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_part;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_bit_sum;
    logic             w_bit_cout;

    full_add_cell u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_c),
        .o_sum  (w_bit_sum),
        .o_cout (w_bit_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_load       = 1'b0;
        w_last       = (r_cnt == LAST_CNT);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                    w_load       = 1'b1;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_next_state = RUN;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The last RUN cycle writes the outputs directly so results are valid on DONE entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_part <= '0;
            r_cnt  <= '0;
            r_c    <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_load) begin
            r_a    <= op_a;
            r_b    <= op_b;
            r_part <= '0;
            r_cnt  <= '0;
            r_c    <= 1'b0;
        end else if (r_state == RUN) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_part <= {w_bit_sum, r_part[WIDTH-1:1]};
            r_c    <= w_bit_cout;
            if (w_last) begin
                r_sum  <= {w_bit_sum, r_part[WIDTH-1:1]};
                r_cout <= w_bit_cout;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // r_c holds the carry into the MSB during the final RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && !w_load && w_last) begin
            r_ovf <= r_c ^ w_bit_cout;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy      = w_busy;
    assign done      = w_done;
    assign sum       = r_sum;
    assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_adder_accum.sv
// Directed bench for serial_adder_accum: arithmetic reference model checked every cycle plus literal checks.
module tb_serial_adder_accum;

    localparam int WIDTH = 8;
`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    serial_adder_accum #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining RUN cycles plus the plain integer sum of the captured operands.
    int               m_run  = 0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_sum  = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf  = 1'b0;
    logic [WIDTH-1:0] m_a    = '0;
    logic [WIDTH-1:0] m_b    = '0;
    logic [WIDTH:0]   m_full;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run  = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_run > 0) begin
            m_run  = m_run - 1;
            m_done = (m_run == 0);
            if (m_run == 0) begin
                m_full = {1'b0, m_a} + {1'b0, m_b};
                m_sum  = m_full[WIDTH-1:0];
                m_cout = m_full[WIDTH];
                m_ovf  = OVF_EN && (m_a[WIDTH-1] == m_b[WIDTH-1])
                                && (m_full[WIDTH-1] != m_a[WIDTH-1]);
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_a   = op_a;
                m_b   = op_b;
                m_run = WIDTH;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", busy, (m_run > 0));
            chk("cyc_done", done, m_done);
            chk("cyc_sum", sum, m_sum);
            chk("cyc_cout", carry_out, m_cout);
            chk("cyc_ovf", ovf, m_ovf);
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_c,
                          input logic exp_v, input string name);
        int  lat;
        int  busy_cnt;
        bit  found;
        lat      = 0;
        busy_cnt = 0;
        found    = 1'b0;
        @(posedge clk); #1;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        for (int i = 0; i <= 20 && !found; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                found = 1'b1;
                lat   = i;
            end
        end
        chk({name, "_timeout"}, found, 1);
        chk({name, "_latency"}, lat, WIDTH);
        chk({name, "_busy_cycles"}, busy_cnt, WIDTH);
        chk({name, "_sum"}, sum, exp_sum);
        chk({name, "_cout"}, carry_out, exp_c);
        chk({name, "_ovf"}, ovf, exp_v);
        @(posedge clk); #1;
        chk({name, "_done_clears"}, done, 0);
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", carry_out, 0);
        chk("rst_ovf", ovf, 0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;

        run_op(8'h03, 8'h05, 8'h08, 1'b0, 1'b0, "add_3_5");
        run_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "add_ff_1");
        run_op(8'h7F, 8'h01, 8'h80, 1'b0, OVF_EN, "add_7f_1");
        run_op(8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0, "add_c8_64");

        // Reset asserted at edge 4 of an operation discards it.
        @(posedge clk); #1;
        op_a  = 8'h11;
        op_b  = 8'h22;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sum", sum, 0);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("midrst_no_done", done_seen, 0);

        // Reset and start together: reset wins.
        @(posedge clk); #1;
        rst_n = 1'b0;
        start = 1'b1;
        op_a  = 8'h05;
        op_b  = 8'h05;
        @(posedge clk); #1;
        chk("rst_start_busy", busy, 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rst_start_busy2", busy, 0);

        // start held high; operands shuffled during RUN, refreshed only at the DONE edges.
        @(posedge clk); #1;
        op_a  = 8'h10;
        op_b  = 8'h20;
        start = 1'b1;
        for (int k = 0; k <= 26; k++) begin
            @(posedge clk); #1;
            if (k == 8) begin
                op_a = 8'hC8;
                op_b = 8'h64;
            end else if (k == 17) begin
                op_a = 8'h80;
                op_b = 8'h80;
            end else begin
                op_a = 8'($urandom);
                op_b = 8'($urandom);
            end
            if (k == 26) start = 1'b0;
            @(negedge clk);
            if (k == 8) begin
                chk("b2b_done_1", done, 1);
                chk("b2b_sum_1", sum, 8'h30);
                chk("b2b_cout_1", carry_out, 0);
            end else if (k == 17) begin
                chk("b2b_done_2", done, 1);
                chk("b2b_sum_2", sum, 8'h2C);
                chk("b2b_cout_2", carry_out, 1);
            end else if (k == 26) begin
                chk("b2b_done_3", done, 1);
                chk("b2b_sum_3", sum, 8'h00);
                chk("b2b_cout_3", carry_out, 1);
                chk("b2b_ovf_3", ovf, OVF_EN);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", busy, 0);
        chk("final_hold_sum", sum, 8'h00);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
